// File: rtl/gmii_rx_framer_if.sv
// gmii_rx_framer_if: GMII receive byte input plus the framed byte-stream and counter outputs.
// master drives GMII bytes and observes results; slave is the framer.
interface gmii_rx_framer_if;
    logic        gmii_en;
    logic [7:0]  gmii_txd;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic        out_fcs_ok;
    logic [15:0] frame_cnt;
    logic [15:0] bad_cnt;
    modport master (
        output gmii_en, gmii_txd,
        input  out_valid, out_data, out_sof, out_eof, out_fcs_ok, frame_cnt, bad_cnt
    );
    modport slave (
        input  gmii_en, gmii_txd,
        output out_valid, out_data, out_sof, out_eof, out_fcs_ok, frame_cnt, bad_cnt
    );
endinterface

// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer: strips preamble/SFD, checks CRC-32 and releases bytes through a D-deep hold buffer.
// GMII_RX_FCS_STRIP_EN defined: D=5, FCS withheld; undefined: D=1, FCS passed through.
module gmii_rx_framer (
    input  logic            gmii_clk,
    input  logic            sys_rst,
    gmii_rx_framer_if.slave bus
);
`ifdef GMII_RX_FCS_STRIP_EN
    localparam int D = 5;
`else
    localparam int D = 1;
`endif
    localparam logic [2:0]  DF      = 3'(D);
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    state_t      r_state;
    logic [2:0]  r_pre_cnt;
    logic [2:0]  r_fill;
    logic [31:0] r_crc;
    logic [7:0]  r_buf [D];
    logic        r_en_prev;
    logic        r_valid;
    logic [7:0]  r_data;
    logic        r_sof;
    logic        r_eof;
    logic        r_ok;
    logic [15:0] r_frame_cnt;
    logic [15:0] r_bad_cnt;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) x = x[0] ? (x >> 1) ^ 32'hEDB88320 : x >> 1;
        return x;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return &v ? v : v + 16'd1;
    endfunction

    // r_en_prev resets high so a burst already in flight at reset release is ignored
    always_ff @(posedge gmii_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= IDLE;
            r_pre_cnt   <= '0;
            r_fill      <= '0;
            r_crc       <= '1;
            r_en_prev   <= 1'b1;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_ok        <= 1'b0;
            r_frame_cnt <= '0;
            r_bad_cnt   <= '0;
            for (int i = 0; i < D; i++) r_buf[i] <= '0;
        end else begin
            r_en_prev <= bus.gmii_en;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_sof     <= 1'b0;
            r_eof     <= 1'b0;
            r_ok      <= 1'b0;
            case (r_state)
                IDLE: if (bus.gmii_en) begin
                    if (r_en_prev) r_state <= DROP;
                    else if (bus.gmii_txd == 8'h55) begin
                        r_state   <= PRE;
                        r_pre_cnt <= 3'd1;
                    end else begin
                        r_state   <= DROP;
                        r_bad_cnt <= sat_inc(r_bad_cnt);
                    end
                end
                PRE: if (!bus.gmii_en) begin
                    r_state   <= IDLE;
                    r_bad_cnt <= sat_inc(r_bad_cnt);
                end else if (bus.gmii_txd == 8'h55 && r_pre_cnt != 3'd7) begin
                    r_pre_cnt <= r_pre_cnt + 3'd1;
                end else if (bus.gmii_txd == 8'hD5) begin
                    r_state <= DATA;
                    r_crc   <= '1;
                    r_fill  <= '0;
                end else begin
                    r_state   <= DROP;
                    r_bad_cnt <= sat_inc(r_bad_cnt);
                end
                // r_fill saturates at D+1: "buffer full and at least one byte already released"
                DATA: if (bus.gmii_en) begin
                    r_crc    <= crc_byte(r_crc, bus.gmii_txd);
                    r_buf[0] <= bus.gmii_txd;
                    for (int i = 1; i < D; i++) r_buf[i] <= r_buf[i-1];
                    if (r_fill >= DF) begin
                        r_valid <= 1'b1;
                        r_data  <= r_buf[D-1];
                        r_sof   <= (r_fill == DF);
                    end
                    if (r_fill <= DF) r_fill <= r_fill + 3'd1;
                end else begin
                    r_state <= IDLE;
                    r_fill  <= '0;
                    if (r_fill > DF) begin
                        r_valid <= 1'b1;
                        r_data  <= r_buf[D-1];
                        r_eof   <= 1'b1;
                        r_ok    <= (r_crc == RESIDUE);
                        if (r_crc == RESIDUE) r_frame_cnt <= sat_inc(r_frame_cnt);
                        else r_bad_cnt <= sat_inc(r_bad_cnt);
                    end else begin
                        r_bad_cnt <= sat_inc(r_bad_cnt);
                    end
                end
                DROP: if (!bus.gmii_en) r_state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid  = r_valid;
    assign bus.out_data   = r_data;
    assign bus.out_sof    = r_sof;
    assign bus.out_eof    = r_eof;
    assign bus.out_fcs_ok = r_ok;
    assign bus.frame_cnt  = r_frame_cnt;
    assign bus.bad_cnt    = r_bad_cnt;
endmodule
